// File: rtl/microcode_sequencer.sv
// microcode_sequencer
// Next-microaddress sequencer for a microprogrammed control unit. It keeps the
// current microaddress (upc), selects the next one from increment, opcode map,
// jump or jump-if-zero, and runs a three-state IDLE/RUN/DONE controller.
// Any next address outside the control store raises a sticky fault and
// returns the sequencer to IDLE instead of loading the bad address.

module microcode_sequencer #(
    parameter int unsigned ROM_DEPTH  = 128,
    parameter logic [15:0] FETCH_ADDR = 16'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] map_addr,
    input  logic [15:0] ucode_next,
    input  logic [1:0]  ucode_sel,
    input  logic        z_flag,
    input  logic        halt,
    input  logic        stall,
    output logic [15:0] upc,
    output logic        running,
    output logic        done,
    output logic        fault
);

    // Controller states; the fourth encoding is unreachable and recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Next-address select field of the control word.
    typedef enum logic [1:0] {
        SEL_INC = 2'b00,
        SEL_MAP = 2'b01,
        SEL_JMP = 2'b10,
        SEL_JZ  = 2'b11
    } sel_t;

    // Candidates are carried one bit wider than upc so that an increment from
    // 16'hFFFF is seen as out of range rather than wrapping to a legal 0.
    localparam logic [16:0] ADDR_LIMIT = 17'(ROM_DEPTH);

    state_t      state;
    state_t      state_nx;
    logic [15:0] upc_nx;
    logic        fault_nx;
    logic [16:0] upc_inc;
    logic [16:0] cand;
    logic        cand_ok;

    // Select the candidate next microaddress from the control word.
    always_comb begin
        // NOTE: every signal written in a combinational block gets a default
        // first, so no path through the case/if tree can leave it unassigned
        // and infer a latch.
        upc_inc = {1'b0, upc} + 17'd1;
        cand    = upc_inc;
        case (ucode_sel)
            SEL_INC: cand = upc_inc;
            SEL_MAP: cand = {1'b0, map_addr};
            SEL_JMP: cand = {1'b0, ucode_next};
            SEL_JZ:  cand = z_flag ? {1'b0, ucode_next} : upc_inc;
            default: cand = upc_inc;
        endcase
        cand_ok = (cand < ADDR_LIMIT);
    end

    // Next-state, next-upc and fault decode; stall beats halt, halt beats select.
    always_comb begin
        state_nx = state;
        upc_nx   = upc;
        fault_nx = fault;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = RUN;
                    upc_nx   = FETCH_ADDR;
                    fault_nx = 1'b0;
                end
            end
            RUN: begin
                if (!stall) begin
                    if (halt) begin
                        // END bit: finish with upc left on the last word.
                        state_nx = DONE;
                    end else if (cand_ok) begin
                        upc_nx = cand[15:0];
                    end else begin
                        // Illegal target: abort rather than fetch garbage.
                        state_nx = IDLE;
                        upc_nx   = 16'd0;
                        fault_nx = 1'b1;
                    end
                end
            end
            DONE: begin
                state_nx = IDLE;
                upc_nx   = FETCH_ADDR;
            end
            default: begin
                state_nx = IDLE;
                upc_nx   = 16'd0;
            end
        endcase
    end

    // State, microaddress and fault registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (rst) begin
            state <= IDLE;
            upc   <= 16'd0;
            fault <= 1'b0;
        end else begin
            state <= state_nx;
            upc   <= upc_nx;
            fault <= fault_nx;
        end
    end

    // Status outputs are pure decodes of the registered state.
    assign running = (state == RUN);
    assign done    = (state == DONE);

endmodule

// File: tb/tb_microcode_sequencer.sv
// tb_microcode_sequencer
// Directed bench for microcode_sequencer with hand-computed expected values.
// Inputs change 1 ns after the rising edge; outputs are sampled at that point.

module tb_microcode_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] map_addr = 16'd0;
    logic [15:0] ucode_next = 16'd0;
    logic [1:0]  ucode_sel = 2'b00;
    logic        z_flag = 1'b0;
    logic        halt = 1'b0;
    logic        stall = 1'b0;
    logic [15:0] upc;
    logic        running;
    logic        done;
    logic        fault;

    int checks = 0;
    int failures = 0;

    microcode_sequencer #(
        .ROM_DEPTH  (128),
        .FETCH_ADDR (16'd0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .map_addr   (map_addr),
        .ucode_next (ucode_next),
        .ucode_sel  (ucode_sel),
        .z_flag     (z_flag),
        .halt       (halt),
        .stall      (stall),
        .upc        (upc),
        .running    (running),
        .done       (done),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [15:0] e_upc,
                             input logic e_run, input logic e_done, input logic e_fault);
        check({tag, ".upc"}, 32'(upc), 32'(e_upc));
        check({tag, ".running"}, 32'(running), 32'(e_run));
        check({tag, ".done"}, 32'(done), 32'(e_done));
        check({tag, ".fault"}, 32'(fault), 32'(e_fault));
    endtask

    // Watchdog: the directed sequence is a few hundred ns long.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Asynchronous reset takes effect before any clock edge.
        #1 rst = 1'b1;
        #2;
        check_all("reset_async", 16'd0, 1'b0, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        step();
        check_all("idle_wait", 16'd0, 1'b0, 1'b0, 1'b0);

        // Start, then three increments.
        start = 1'b1;
        step();
        start = 1'b0;
        check_all("start", 16'd0, 1'b1, 1'b0, 1'b0);
        ucode_sel = 2'b00;
        for (int i = 1; i <= 3; i++) begin
            step();
            check($sformatf("inc%0d", i), 32'(upc), 32'(i));
        end

        // start is ignored while running.
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_in_run", 32'(upc), 32'd4);

        // Stall holds upc even with a jump selected.
        stall = 1'b1; ucode_sel = 2'b10; ucode_next = 16'd99;
        step();
        check_all("stall_hold", 16'd4, 1'b1, 1'b0, 1'b0);
        stall = 1'b0;

        // Map then jump.
        ucode_sel = 2'b01; map_addr = 16'd45;
        step();
        check("map45", 32'(upc), 32'd45);
        ucode_sel = 2'b10; ucode_next = 16'd3;
        step();
        check("jmp3", 32'(upc), 32'd3);

        // Jump-if-zero taken and not taken from 66.
        ucode_next = 16'd66;
        step();
        check("jmp66", 32'(upc), 32'd66);
        ucode_sel = 2'b11; z_flag = 1'b1; ucode_next = 16'd67;
        step();
        check("jz_taken", 32'(upc), 32'd67);
        ucode_sel = 2'b10; ucode_next = 16'd66;
        step();
        ucode_sel = 2'b11; z_flag = 1'b0; ucode_next = 16'd10;
        step();
        check("jz_not_taken1", 32'(upc), 32'd67);
        step();
        check("jz_not_taken2", 32'(upc), 32'd68);

        // halt under stall holds; releasing stall finishes.
        halt = 1'b1; stall = 1'b1; ucode_sel = 2'b10; ucode_next = 16'd5;
        step();
        check_all("halt_stall1", 16'd68, 1'b1, 1'b0, 1'b0);
        step();
        check_all("halt_stall2", 16'd68, 1'b1, 1'b0, 1'b0);
        stall = 1'b0;
        step();
        check_all("done_pulse", 16'd68, 1'b0, 1'b1, 1'b0);
        halt = 1'b0;
        start = 1'b1;              // ignored in DONE
        step();
        start = 1'b0;
        check_all("after_done", 16'd0, 1'b0, 1'b0, 1'b0);
        step();
        check_all("idle_after_done", 16'd0, 1'b0, 1'b0, 1'b0);

        // Increment past the last word faults without wrapping.
        start = 1'b1;
        step();
        start = 1'b0;
        ucode_sel = 2'b10; ucode_next = 16'd127;
        step();
        check("jmp127", 32'(upc), 32'd127);
        ucode_sel = 2'b00;
        step();
        check_all("fault_inc", 16'd0, 1'b0, 1'b0, 1'b1);
        step();
        check("fault_sticky", 32'(fault), 32'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        check_all("fault_clear", 16'd0, 1'b1, 1'b0, 1'b0);

        // Map to the last legal word, then to an illegal one.
        ucode_sel = 2'b01; map_addr = 16'd127;
        step();
        check_all("map127", 16'd127, 1'b1, 1'b0, 1'b0);
        map_addr = 16'd200;
        step();
        check_all("fault_map200", 16'd0, 1'b0, 1'b0, 1'b1);

        // Jump to exactly ROM_DEPTH faults.
        start = 1'b1;
        step();
        start = 1'b0;
        ucode_sel = 2'b10; ucode_next = 16'd128;
        step();
        check_all("fault_jmp128", 16'd0, 1'b0, 1'b0, 1'b1);

        // Untaken jz with an illegal target is harmless.
        start = 1'b1;
        step();
        start = 1'b0;
        ucode_sel = 2'b11; z_flag = 1'b0; ucode_next = 16'd500;
        step();
        check_all("jz_untaken_bad", 16'd1, 1'b1, 1'b0, 1'b0);

        // Reset mid-run at upc=20 clears everything at once.
        ucode_sel = 2'b10; ucode_next = 16'd20;
        step();
        check("jmp20", 32'(upc), 32'd20);
        ucode_sel = 2'b00; halt = 1'b1;
        #2 rst = 1'b1;
        #1;
        check_all("rst_mid_run", 16'd0, 1'b0, 1'b0, 1'b0);
        step();
        check_all("rst_held", 16'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0; halt = 1'b0;
        step();
        step();
        check_all("rst_wait_start", 16'd0, 1'b0, 1'b0, 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        check_all("restart", 16'd0, 1'b1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
